// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/load-store requesters, the arbiter and the word RAM.
// The arbiter uses the slave modport; the requester/RAM side uses master.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Handshake: a requester raises req and holds its fields stable until gnt is high;
    // the request is consumed in the cycle gnt is high. rvalid is a one-cycle pulse
    // one cycle after the grant and has no back-pressure.
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              if_err;

    logic              ls_req;
    logic              ls_we;
    logic [ADDR_W-1:0] ls_addr;
    logic [DATA_W-1:0] ls_wdata;
    logic              ls_gnt;
    logic              ls_rvalid;
    logic [DATA_W-1:0] ls_rdata;
    logic              ls_err;

    logic [ADDR_W-1:0] mem_ad;
    logic [DATA_W-1:0] mem_d;
    logic              mem_we;
    logic [DATA_W-1:0] mem_q;

    modport master (
        output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_q,
        input  if_gnt, if_rvalid, if_rdata, if_err,
        input  ls_gnt, ls_rvalid, ls_rdata, ls_err,
        input  mem_ad, mem_d, mem_we
    );

    modport slave (
        input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_q,
        output if_gnt, if_rvalid, if_rdata, if_err,
        output ls_gnt, ls_rvalid, ls_rdata, ls_err,
        output mem_ad, mem_d, mem_we
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter for instruction fetch and load/store, with bounded
// fetch starvation and a one-deep response pipeline that routes read data back.
module mem_port_arbiter #(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int MAX_LS_STREAK = 4
) (
    input  logic                clk,
    input  logic                nreset,
    mem_port_arbiter_if.slave   bus,
    output logic [1:0]          dbg_owner_o,
    output logic [3:0]          dbg_streak_o
);
    localparam logic [3:0] STREAK_MAX = 4'(MAX_LS_STREAK);

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_IF    = 2'd1,
        OWN_LS_RD = 2'd2,
        OWN_LS_WR = 2'd3
    } owner_e;

    owner_e            owner_q, owner_d;
    logic              err_q, err_d;
    logic [3:0]        streak_q, streak_d;
    logic [ADDR_W-1:0] last_ad_q, last_ad_d;

    logic              if_gnt, ls_gnt, mem_we, force_if;
    logic [ADDR_W-1:0] mem_ad;
    logic [DATA_W-1:0] mem_d;

    always_ff @(posedge clk) begin
        if (nreset) begin
            owner_q   <= OWN_NONE;
            err_q     <= 1'b0;
            streak_q  <= 4'd0;
            last_ad_q <= '0;
        end else begin
            owner_q   <= owner_d;
            err_q     <= err_d;
            streak_q  <= streak_d;
            last_ad_q <= last_ad_d;
        end
    end

    // Fetch wins a contended cycle only once load/store has used up its streak.
    assign force_if = bus.if_req && (streak_q == STREAK_MAX);

    always_comb begin
        owner_d   = OWN_NONE;
        err_d     = 1'b0;
        streak_d  = streak_q;
        last_ad_d = last_ad_q;
        if_gnt    = 1'b0;
        ls_gnt    = 1'b0;
        mem_ad    = last_ad_q;
        mem_d     = '0;
        mem_we    = 1'b0;
        if (nreset) begin
            mem_ad = '0;
        end else begin
            if (bus.ls_req && !force_if) begin
                ls_gnt  = 1'b1;
                mem_ad  = bus.ls_addr;
                mem_d   = bus.ls_wdata;
                err_d   = |bus.ls_addr[1:0];
                mem_we  = bus.ls_we && !err_d;
                owner_d = bus.ls_we ? OWN_LS_WR : OWN_LS_RD;
            end else if (bus.if_req) begin
                if_gnt  = 1'b1;
                mem_ad  = bus.if_addr;
                err_d   = |bus.if_addr[1:0];
                owner_d = OWN_IF;
            end
            last_ad_d = mem_ad;
            if (!bus.if_req || if_gnt) begin
                streak_d = 4'd0;
            end else if (ls_gnt && (streak_q != STREAK_MAX)) begin
                streak_d = streak_q + 4'd1;
            end
        end
    end

    assign bus.if_gnt = if_gnt;
    assign bus.ls_gnt = ls_gnt;
    assign bus.mem_ad = mem_ad;
    assign bus.mem_d  = mem_d;
    assign bus.mem_we = mem_we;

    // Responses are masked while reset is asserted so an in-flight access is dropped.
    assign bus.if_rvalid = !nreset && (owner_q == OWN_IF);
    assign bus.if_err    = bus.if_rvalid && err_q;
    assign bus.if_rdata  = (bus.if_rvalid && !err_q) ? bus.mem_q : '0;

    assign bus.ls_rvalid = !nreset && ((owner_q == OWN_LS_RD) || (owner_q == OWN_LS_WR));
    assign bus.ls_err    = bus.ls_rvalid && err_q;
    assign bus.ls_rdata  = (!nreset && (owner_q == OWN_LS_RD) && !err_q) ? bus.mem_q : '0;

    assign dbg_owner_o  = owner_q;
    assign dbg_streak_o = streak_q;
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port word RAM between the instruction-fetch requester and the load/store requester inside cpu.
- Grants at most one access per cycle and drives the RAM address, data and write-enable.
- Tracks which requester owns the in-flight read and routes the RAM's 1-cycle-latency read data back to it.
- Rejects misaligned accesses and bounds fetch starvation.

Parameters:
- ADDR_W, 32, width of all address buses.
- DATA_W, 32, width of all data buses.
- MAX_LS_STREAK, 4, max consecutive load/store grants while if_req is pending before fetch is forced a grant; legal range 1..15.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- nreset  input  1  synchronous, active-high reset: nreset=1 at a rising edge resets all state.
- if_req  input  1  fetch request; held with if_addr stable until if_gnt.
- if_addr  input  ADDR_W  fetch byte address.
- if_gnt  output  1  fetch request accepted this cycle (combinational).
- if_rvalid  output  1  fetch response valid (registered).
- if_rdata  output  DATA_W  fetch read data, qualified by if_rvalid.
- if_err  output  1  with if_rvalid: access was misaligned.
- ls_req  input  1  load/store request; held with ls_we/ls_addr/ls_wdata stable until ls_gnt.
- ls_we  input  1  1=store, 0=load.
- ls_addr  input  ADDR_W  load/store byte address.
- ls_wdata  input  DATA_W  store data.
- ls_gnt  output  1  load/store request accepted this cycle (combinational).
- ls_rvalid  output  1  load/store response valid (registered); loads and stores both respond.
- ls_rdata  output  DATA_W  load data; 0 for stores and errors.
- ls_err  output  1  with ls_rvalid: access was misaligned.
- mem_ad  output  ADDR_W  RAM address.
- mem_d  output  DATA_W  RAM write data.
- mem_we  output  1  RAM write enable.
- mem_q  input  DATA_W  RAM read data; valid the cycle after the address is presented.

Behaviour:
- Reset (nreset=1):
  - resp_owner=NONE, streak=0.
  - All outputs 0: gnt, rvalid, err, rdata, mem_we, mem_ad, mem_d.
  - Requests present during reset are not granted and never reach the RAM.
- Arbitration, combinational in the request cycle:
  - Only ls_req: LS granted.
  - Only if_req: IF granted.
  - Both: LS granted unless streak==MAX_LS_STREAK, in which case IF granted.
  - Exactly one gnt high per cycle when any request is present.
- Streak counter:
  - Increments on each LS grant while if_req=1, saturating at MAX_LS_STREAK.
  - Clears on any IF grant, or in any cycle with if_req=0.
- RAM drive:
  - mem_ad = granted requester's address; it holds the last granted address when idle.
  - mem_d = ls_wdata when LS is granted, else 0.
  - mem_we = 1 only for a granted, aligned store.
- Alignment: addr[1:0] != 0 is misaligned.
  - The request is still granted (consumed).
  - mem_we is forced 0.
  - The response carries err=1 and rdata=0.
- Response pipeline:
  - resp_owner is registered at grant: one of NONE, IF, LS_RD, LS_WR, plus an err bit.
  - Next cycle the matching rvalid pulses for exactly 1 cycle.
  - if_rdata = mem_q for an IF owner; ls_rdata = mem_q for LS_RD, 0 for LS_WR or err. The non-owner rdata is 0.
- Fully pipelined: a new grant is allowed every cycle, including the cycle a prior response is delivered.
- Read-after-write: a load granted the cycle after a store to the same address returns the new data, because the RAM write completes at the store's edge.
- Reset mid-operation: a pending response is dropped (rvalid stays 0) and streak clears.
- Requesters may drop req before gnt; no state is kept for ungranted requests.

Test Plan:
1. Reset with if_req=ls_req=1, then nreset=1 for 2 cycles: no gnt, mem_we=0, all rvalid 0.
2. Fetch-only read: RAM[0x10]=0xDEADBEEF, if_req, if_addr=0x10. Required: if_gnt in cycle 0; if_rvalid=1 and if_rdata=0xDEADBEEF in cycle 1; ls_rvalid=0.
3. Store then load:
   - Store ls_addr=0x20, ls_wdata=0x12345678 in cycle 0: mem_we=1, ls_rvalid in cycle 1 with ls_rdata=0.
   - Load of 0x20 in cycle 1: ls_rdata=0x12345678 in cycle 2.
4. Contention with MAX_LS_STREAK=4: if_req and ls_req held high continuously. Grant sequence is LS,LS,LS,LS,IF,LS,LS,LS,LS,IF; responses are routed to the matching port each following cycle.
5. Misaligned load at ls_addr=0x22 and misaligned fetch at if_addr=0x41: gnt issued, mem_we=0, next cycle rvalid=1, err=1, rdata=0.
6. Reset mid-flight: fetch granted in cycle 0, nreset=1 in cycle 1. No if_rvalid, streak=0; the first request after reset is granted normally.
